// File: rtl/micromind_pkg.sv
// micromind_pkg: shared direction/mode encodings and timer state type.
package micromind_pkg;
  localparam logic MODE_CONT    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;
  localparam logic DIR_UP       = 1'b0;
  localparam logic DIR_DOWN     = 1'b1;
  typedef enum logic {RUN, DONE} state_t;
endpackage

// File: rtl/micromind_prescaler.sv
// micromind_prescaler: divides enabled cycles, ticking every prescale+1 of them.
module micromind_prescaler #(
  parameter int PRE_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 clr,
  input  logic [PRE_WIDTH-1:0] prescale,
  output logic                 tick
);
  logic [PRE_WIDTH-1:0] r_pcnt;
  assign tick = en && (r_pcnt == prescale);
  // A pcnt already past prescale just keeps counting until it wraps and matches.
  always_ff @(posedge clk or posedge reset)
    if (reset) r_pcnt <= '0;
    else if (clr) r_pcnt <= '0;
    else if (en) r_pcnt <= tick ? '0 : r_pcnt + 1'b1;
endmodule

// File: rtl/micromind_timer.sv
// micromind_timer: prescaled up/down modulo counter with one-shot mode, tc pulse and sticky ovf.
module micromind_timer
  import micromind_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int PRE_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 clr,
  input  logic                 load,
  input  logic [WIDTH-1:0]     load_val,
  input  logic                 dir,
  input  logic                 mode,
  input  logic [WIDTH-1:0]     limit,
  input  logic [PRE_WIDTH-1:0] prescale,
  input  logic                 ovf_clr,
  output logic [WIDTH-1:0]     out,
  output logic                 tc,
  output logic                 ovf,
  output logic                 busy
);
  state_t           r_state, w_state_n;
  logic [WIDTH-1:0] r_out, w_out_n;
  logic             r_tc, r_ovf, w_tc_n, w_ovf_n, w_tick, w_term;
  micromind_prescaler #(.PRE_WIDTH(PRE_WIDTH)) u_pre (
    .clk(clk), .reset(reset), .en(en), .clr(clr | load), .prescale(prescale), .tick(w_tick)
  );
  assign w_term = (dir == DIR_DOWN) ? (r_out == '0) : (r_out >= limit);
  always_comb begin
    w_state_n = r_state;
    w_out_n   = r_out;
    w_tc_n    = 1'b0;
    w_ovf_n   = r_ovf & ~ovf_clr;
    if (clr) begin
      w_out_n   = '0;
      w_state_n = RUN;
    end else if (load) begin
      w_out_n   = load_val;
      w_state_n = RUN;
    end else if (w_tick && r_state == RUN) begin
      if (w_term) begin
        w_tc_n  = 1'b1;
        w_ovf_n = 1'b1;
        if (mode == MODE_ONESHOT) w_state_n = DONE;
        else w_out_n = (dir == DIR_DOWN) ? limit : '0;
      end else begin
        w_out_n = (dir == DIR_DOWN) ? r_out - 1'b1 : r_out + 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= RUN;
      r_out   <= '0;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_out   <= w_out_n;
      r_tc    <= w_tc_n;
      r_ovf   <= w_ovf_n;
    end
  assign out  = r_out;
  assign tc   = r_tc;
  assign ovf  = r_ovf;
  assign busy = (r_state == RUN);
endmodule

// File: tb/tb_micromind_timer.sv
// tb_micromind_timer: directed self-checking bench for micromind_timer.
module tb_micromind_timer;
  logic       clk = 1'b0;
  logic       reset, en, clr, load, dir, mode, ovf_clr;
  logic [7:0] load_val, limit, prescale, out;
  logic       tc, ovf, busy;
  int         errors = 0;
  int         checks = 0;
  micromind_timer #(.WIDTH(8), .PRE_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .load(load), .load_val(load_val),
    .dir(dir), .mode(mode), .limit(limit), .prescale(prescale), .ovf_clr(ovf_clr),
    .out(out), .tc(tc), .ovf(ovf), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 1'b1; en = 1'b0; clr = 1'b0; load = 1'b0; dir = 1'b0; mode = 1'b0;
    ovf_clr = 1'b0; load_val = 8'd0; limit = 8'd5; prescale = 8'd0;
    step(); step();
    chk("rst_out", out, 0); chk("rst_tc", tc, 0); chk("rst_ovf", ovf, 0); chk("rst_busy", busy, 1);
    reset = 1'b0; en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("up_out", out, i); chk("up_tc", tc, 0);
    end
    step();
    chk("wrap_out", out, 0); chk("wrap_tc", tc, 1); chk("wrap_ovf", ovf, 1);
    step();
    chk("post_wrap_out", out, 1); chk("post_wrap_tc", tc, 0); chk("post_wrap_ovf", ovf, 1);
    prescale = 8'd3; limit = 8'd255; clr = 1'b1;
    step();
    chk("clr_out", out, 0); chk("clr_ovf_kept", ovf, 1);
    clr = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      repeat (3) begin step(); chk("pre_hold", out, k - 1); end
      step(); chk("pre_tick", out, k);
    end
    step(); step();
    en = 1'b0;
    repeat (10) begin step(); chk("en_freeze", out, 2); end
    en = 1'b1;
    step(); chk("resume_phase_a", out, 2);
    step(); chk("resume_phase_b", out, 3);
    prescale = 8'd0; dir = 1'b1; mode = 1'b1; load = 1'b1; load_val = 8'd3;
    step();
    chk("ld_out", out, 3); chk("ld_busy", busy, 1); chk("ld_tc", tc, 0);
    load = 1'b0;
    for (int i = 2; i >= 0; i--) begin
      step(); chk("dn_out", out, i); chk("dn_tc", tc, 0);
    end
    step();
    chk("os_out", out, 0); chk("os_tc", tc, 1); chk("os_busy", busy, 0);
    repeat (20) begin
      step(); chk("done_out", out, 0); chk("done_busy", busy, 0); chk("done_tc", tc, 0);
    end
    mode = 1'b0;
    step(); chk("done_mode_busy", busy, 0); chk("done_mode_out", out, 0);
    mode = 1'b1; load = 1'b1; load_val = 8'd7;
    step(); chk("reload_out", out, 7); chk("reload_busy", busy, 1);
    load = 1'b0; clr = 1'b1; load_val = 8'd9; dir = 1'b0; mode = 1'b0; limit = 8'd2;
    load = 1'b1;
    step(); chk("clr_load_out", out, 0); chk("clr_load_tc", tc, 0);
    clr = 1'b0; load = 1'b0; ovf_clr = 1'b1;
    step(); chk("ovfclr_out", out, 1); chk("ovfclr_ovf", ovf, 0);
    ovf_clr = 1'b0;
    step(); chk("pre_wrap2", out, 2);
    ovf_clr = 1'b1;
    step(); chk("wrap2_out", out, 0); chk("wrap2_tc", tc, 1); chk("set_wins", ovf, 1);
    step(); chk("ovf_cleared", ovf, 0); chk("after_wrap2", out, 1);
    ovf_clr = 1'b0; limit = 8'd4; load = 1'b1; load_val = 8'd9;
    step(); chk("ld9_out", out, 9);
    load = 1'b0;
    step(); chk("above_lim_out", out, 0); chk("above_lim_tc", tc, 1);
    limit = 8'd0;
    step(); chk("lim0_out_a", out, 0); chk("lim0_tc_a", tc, 1);
    step(); chk("lim0_out_b", out, 0); chk("lim0_tc_b", tc, 1);
    dir = 1'b1;
    step(); chk("lim0_dn_out", out, 0); chk("lim0_dn_tc", tc, 1);
    dir = 1'b0; mode = 1'b1; limit = 8'h37; load = 1'b1; load_val = 8'h37;
    step(); chk("ld37_out", out, 8'h37);
    load = 1'b0;
    step(); chk("os37_out", out, 8'h37); chk("os37_busy", busy, 0); chk("os37_tc", tc, 1);
    reset = 1'b1;
    #1;
    chk("arst_out", out, 0); chk("arst_tc", tc, 0); chk("arst_ovf", ovf, 0); chk("arst_busy", busy, 1);
    mode = 1'b0; limit = 8'd255;
    #2 reset = 1'b0;
    step(); chk("post_rst_a", out, 1);
    step(); chk("post_rst_b", out, 2); chk("post_rst_busy", busy, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
